fadd_pipe: RTL
==============

FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width in bits.
REQ-002 SHALL have parameter MW, default 23, stored mantissa (fraction) width in bits; word width W = 1+EW+MW.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port x1  input  W  first IEEE-754-format operand.
REQ-008 SHALL have port x2  input  W  second IEEE-754-format operand.
REQ-009 SHALL have port sub  input  1  0: y = x1 + x2; 1: y = x1 - x2 (x2 sign inverted).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port y  output  W  rounded result.
REQ-013 SHALL have port ovf  output  1  result overflowed to infinity.
REQ-014 SHALL have port nv  output  1  invalid operation (inf - inf, or any signalling-NaN input).

Function
REQ-015 SHALL transfer operands when in_valid & in_ready, results when out_valid & out_ready.
REQ-016 SHALL use 3 register stages: S1 align (swap, exponent diff, sticky shift), S2 add/subtract + leading-zero normalise, S3 round-to-nearest-even + exception select.
REQ-017 SHALL produce a result 3 cycles after acceptance when out_ready is held high; throughput 1 op/cycle.
REQ-018 SHALL advance stage k when stage k is empty or stage k+1 advances; in_ready = !S1_valid | S1_advance (combinational from out_ready, no bubble).
REQ-019 SHALL hold y/ovf/nv/out_valid stable while out_valid & !out_ready.
REQ-020 SHALL carry 3 guard bits (guard, round, sticky) of width MW+4 significand; sticky = OR of all bits shifted out, shift saturating at MW+4.
REQ-021 SHALL treat exponent 0 as subnormal (hidden bit 0, effective exponent 1) and produce subnormal outputs (gradual underflow), including rounding up into the smallest normal.
REQ-022 SHALL hold normalisation exponent in EW+2-bit signed arithmetic; result exponent >= 2^EW-1 after rounding yields ±infinity, mantissa 0, ovf=1.
REQ-023 SHALL return canonical quiet NaN {0, all-ones exponent, 1, zeros} for any NaN input or inf-inf; nv=1 for inf-inf or signalling NaN input (fraction MSB 0).
REQ-024 SHALL return infinity of operand sign for inf ± finite, and same-sign inf + inf.
REQ-025 SHALL return +0 for exact-zero sums of opposite-sign operands; -0 only when both effective operands are -0.
REQ-026 SHALL drive ovf=0, nv=0 for all results except those of REQ-022/REQ-023.

Reset
REQ-027 SHALL on rstn low clear all stage valid bits immediately; out_valid=0, y=0, ovf=0, nv=0; in-flight operations discarded.
REQ-028 SHALL leave in_ready=1 while in reset-released empty state; first acceptance possible in the first clk edge after rstn rises.
REQ-029 SHALL not require datapath registers to be reset (only valid bits and output registers).

Structure
REQ-030 SHALL place EW/MW defaults, field-extract helper functions, qNaN constant and stage payload struct typedefs in shared package fp_pkg.
REQ-031 SHALL implement S3 rounding/exception logic as sub-module fp_round_rne (parametrised EW, MW); all other logic in fadd_pipe.

Verification
REQ-032 SHALL check 0x3F800000 + 0x40000000, sub=0 -> y=0x40400000, ovf=0, nv=0, out_valid exactly 3 cycles after accept.
REQ-033 SHALL check 0x3F800000 + 0x33800000 (tie) -> 0x3F800000; 0x3F800001 + 0x33800000 -> 0x3F800002 (round to even).
REQ-034 SHALL check 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ovf=1; 0x7F800000 sub 0x7F800000 -> 0x7FC00000, nv=1.
REQ-035 SHALL check 0x00000001 + 0x00000001 -> 0x00000002; 0x3F800000 sub 0x3F800000 -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
REQ-036 SHALL check backpressure: 5 back-to-back ops with out_ready=0 -> exactly 3 accepted, in_ready low, y stable; out_ready=1 -> results in issue order, no loss or duplicate.
REQ-037 SHALL check rstn asserted with 3 ops in flight -> out_valid=0 same cycle, no result emitted after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format defaults, field extraction,
// canonical quiet NaN and the width-independent special-case payload.
package fp_pkg;
  localparam int EW_DEF = 8;
  localparam int MW_DEF = 23;
  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  // Special-case verdict made at decode and carried unchanged to rounding.
  typedef struct packed {
    logic spc;  // result is decided by the special path
    logic nan;  // special result is the canonical qNaN
    logic sgn;  // sign of the infinity when not NaN
    logic nv;   // invalid-operation flag
  } spc_t;

  function automatic logic [15:0] exp_of(input logic [63:0] w, input int ew, input int mw);
    return 16'((w >> mw) & ((64'd1 << ew) - 64'd1));
  endfunction

  function automatic logic [63:0] frac_of(input logic [63:0] w, input int mw);
    return w & ((64'd1 << mw) - 64'd1);
  endfunction

  // {0, all-ones exponent, 1, zeros}
  function automatic logic [63:0] qnan_of(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand plus exception select.
module fp_round_rne import fp_pkg::*; #(
  parameter int EW = EW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic                 sgn,
  input  logic signed [EW+1:0] exp,
  input  logic [MW+3:0]        nrm,
  input  spc_t                 spc,
  output logic [EW+MW:0]       y,
  output logic                 ovf,
  output logic                 nv
);
  localparam int XW = EW + 2;

  logic                 up, big;
  logic [MW+1:0]        mr;
  logic signed [XW-1:0] ef;
  logic [MW-1:0]        frac;

  // RNE increment; a carry out renormalises, a subnormal gaining its hidden bit becomes exponent 1
  always_comb begin
    up = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
    mr = {1'b0, nrm[MW+3:3]} + {{(MW+1){1'b0}}, up};
    if (mr[MW+1]) begin
      ef   = exp + XW'(1);
      frac = mr[MW:1];
    end else begin
      ef   = mr[MW] ? exp : '0;
      frac = mr[MW-1:0];
    end
    big = ~ef[XW-1] & ((|ef[XW-2:EW]) | (&ef[EW-1:0]));
    nv  = spc.spc & spc.nv;
    ovf = ~spc.spc & big;
    if (spc.spc)
      y = spc.nan ? (EW+MW+1)'(qnan_of(EW, MW)) : {spc.sgn, {EW{1'b1}}, {MW{1'b0}}};
    else if (big)
      y = {sgn, {EW{1'b1}}, {MW{1'b0}}};
    else
      y = {sgn, ef[EW-1:0], frac};
  end
endmodule

// File: rtl/fadd_pipe.sv
// Three-stage IEEE-754 adder/subtractor: align, add+normalise, round.
module fadd_pipe import fp_pkg::*; #(
  parameter int EW = EW_DEF,
  parameter int MW = MW_DEF,
  localparam int W = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic         nv
);
  localparam int WS = MW + 4;  // hidden + fraction + guard/round/sticky
  localparam int XW = EW + 2;

  typedef struct packed {
    logic          sgn;
    logic          esub;
    logic [EW-1:0] exp;
    logic [WS-1:0] big;
    logic [WS-1:0] sml;
    spc_t          spc;
  } s1_t;

  typedef struct packed {
    logic                 sgn;
    logic signed [XW-1:0] exp;
    logic [WS-1:0]        nrm;
    spc_t                 spc;
  } s2_t;

  logic [3:1] vld_pipe;
  logic       en1, en2, en3;
  s1_t        s1_d, p1;
  s2_t        s2_d, p2;

  assign en3       = ~vld_pipe[3] | out_ready;
  assign en2       = ~vld_pipe[2] | en3;
  assign en1       = ~vld_pipe[1] | en2;
  assign in_ready  = en1;
  assign out_valid = vld_pipe[3];

  logic [EW-1:0] e1, e2;
  logic [MW-1:0] f1, f2;
  logic          sa, sb;

  assign e1 = EW'(exp_of(64'(x1), EW, MW));
  assign e2 = EW'(exp_of(64'(x2), EW, MW));
  assign f1 = MW'(frac_of(64'(x1), MW));
  assign f2 = MW'(frac_of(64'(x2), MW));
  assign sa = x1[W-1];
  assign sb = x2[W-1] ^ sub;

  // S1: classify, order by magnitude, align the smaller operand with a sticky shift
  always_comb begin
    logic          nan1, nan2, inf1, inf2, swap, lost;
    logic [EW-1:0] ea, eb, d;
    logic [MW:0]   ma, mb;
    logic [WS-1:0] sext;
    int            sh;
    nan1 = (&e1) & (|f1);
    nan2 = (&e2) & (|f2);
    inf1 = (&e1) & ~(|f1);
    inf2 = (&e2) & ~(|f2);
    ea   = (e1 == '0) ? EW'(1) : e1;
    eb   = (e2 == '0) ? EW'(1) : e2;
    ma   = {|e1, f1};
    mb   = {|e2, f2};
    swap = {e2, f2} > {e1, f1};
    s1_d.sgn  = swap ? sb : sa;
    s1_d.esub = sa ^ sb;
    s1_d.exp  = swap ? eb : ea;
    s1_d.big  = {(swap ? mb : ma), 3'b000};
    sext      = {(swap ? ma : mb), 3'b000};
    d         = swap ? (eb - ea) : (ea - eb);
    sh        = (int'(d) >= WS) ? WS : int'(d);
    lost      = |(sext & ~({WS{1'b1}} << sh));
    s1_d.sml  = (sext >> sh) | {{(WS-1){1'b0}}, lost};
    s1_d.spc.spc = nan1 | nan2 | inf1 | inf2;
    s1_d.spc.nan = nan1 | nan2 | (inf1 & inf2 & (sa ^ sb));
    s1_d.spc.sgn = inf1 ? sa : sb;
    s1_d.spc.nv  = (nan1 & ~f1[MW-1]) | (nan2 & ~f2[MW-1]) | (inf1 & inf2 & (sa ^ sb));
  end

  // S2: magnitude add/subtract, then normalise without dropping below exponent 1
  always_comb begin
    logic [WS:0] sum;
    int          lz, lim, shl;
    sum = p1.esub ? ({1'b0, p1.big} - {1'b0, p1.sml}) : ({1'b0, p1.big} + {1'b0, p1.sml});
    s2_d.exp = signed'({2'b00, p1.exp});
    s2_d.spc = p1.spc;
    s2_d.sgn = (sum == '0) ? (p1.sgn & ~p1.esub) : p1.sgn;
    lz  = WS;
    lim = 0;
    shl = 0;
    if (sum[WS]) begin
      s2_d.nrm = {sum[WS:2], sum[1] | sum[0]};
      s2_d.exp = s2_d.exp + XW'(1);
    end else begin
      for (int i = 0; i < WS; i++)
        if (sum[i]) lz = WS - 1 - i;
      lim = int'(s2_d.exp) - 1;
      shl = (lz < lim) ? lz : lim;
      s2_d.nrm = sum[WS-1:0] << shl;
      s2_d.exp = s2_d.exp - XW'(shl);
    end
  end

  logic [W-1:0] r_y;
  logic         r_ovf, r_nv;

  fp_round_rne #(.EW(EW), .MW(MW)) u_rnd (
    .sgn (p2.sgn),
    .exp (p2.exp),
    .nrm (p2.nrm),
    .spc (p2.spc),
    .y   (r_y),
    .ovf (r_ovf),
    .nv  (r_nv)
  );

  // Stage occupancy; a stage loads whenever it is empty or its successor moves
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (en2) vld_pipe[2] <= vld_pipe[1];
      if (en3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // Datapath payloads need no reset; their valid bits qualify them
  always_ff @(posedge clk) begin
    if (en1) p1 <= s1_d;
    if (en2) p2 <= s2_d;
  end

  // Output registers hold steady under backpressure
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y   <= '0;
      ovf <= 1'b0;
      nv  <= 1'b0;
    end else if (en3 && vld_pipe[2]) begin
      y   <= r_y;
      ovf <= r_ovf;
      nv  <= r_nv;
    end
  end
endmodule
